// File: rtl/vector_lsu_if.sv
// Vector load/store unit bus interface.
// Bundles the request port (start/op/base_addr/rd_idx/st_data), the status
// outputs (busy/done), the word-wide memory port (mem_addr/mem_we/mem_wdata/
// mem_rdata) and the register-file write port (WD/WEV/RD).
// Modports: slave = the LSU itself, master = requester plus memory side.
interface vector_lsu_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 16
);
    logic                         start;
    logic                         op;
    logic [ADDR_W-1:0]            base_addr;
    logic [4:0]                   rd_idx;
    logic [WIDTH-1:0][WIDTH-1:0]  st_data;

    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_we;
    logic [WIDTH-1:0]             mem_wdata;
    logic [WIDTH-1:0]             mem_rdata;

    logic [WIDTH-1:0][WIDTH-1:0]  WD;
    logic                         WEV;
    logic [4:0]                   RD;
    logic                         busy;
    logic                         done;

    modport slave (
        input  start, op, base_addr, rd_idx, st_data, mem_rdata,
        output mem_addr, mem_we, mem_wdata, WD, WEV, RD, busy, done
    );

    modport master (
        output start, op, base_addr, rd_idx, st_data, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, WD, WEV, RD, busy, done
    );
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves a WIDTH-element vector between the register
// file and a word-addressed memory, one element per cycle.
// Ports: clk, rst (async, active-high) and bus (vector_lsu_if.slave) carrying
// the request, memory port, register-file write port and busy/done status.
// All outputs are registered; next-cycle output values are computed together
// with the next state.
module vector_lsu #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    vector_lsu_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LLAST = 3'd2,
        WB    = 3'd3,
        STORE = 3'd4,
        SDONE = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]           base_q, base_d;
    logic [4:0]                  rdi_q, rdi_d;
    logic [WIDTH-1:0][WIDTH-1:0] st_q, st_d;

    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic                        mem_we_q, mem_we_d;
    logic [WIDTH-1:0]            mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0][WIDTH-1:0] wd_q, wd_d;
    logic                        wev_q, wev_d;
    logic [4:0]                  rd_out_q, rd_out_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    // Next state, counter, latched request and next-cycle output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        rdi_d       = rdi_q;
        st_d        = st_q;
        wd_d        = wd_q;
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
        wev_d       = 1'b0;
        rd_out_d    = '0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    rdi_d      = bus.rd_idx;
                    st_d       = bus.st_data;
                    cnt_d      = '0;
                    mem_addr_d = bus.base_addr;
                    if (bus.op) begin
                        state_d     = STORE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.st_data[0];
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // Read data lags the address by one cycle, so lane cnt-1 lands now.
                if (cnt_q != '0) begin
                    wd_d[CNT_W'(cnt_q - CNT_W'(1))] = bus.mem_rdata;
                end
                if (cnt_q == LAST) begin
                    state_d = LLAST;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = CNT_W'(cnt_q + CNT_W'(1));
                    mem_addr_d = ADDR_W'(base_q + ADDR_W'(cnt_d));
                end
            end
            LLAST: begin
                wd_d[WIDTH-1] = bus.mem_rdata;
                state_d       = WB;
                wev_d         = 1'b1;
                rd_out_d      = rdi_q;
                done_d        = 1'b1;
            end
            WB: begin
                state_d = IDLE;
            end
            STORE: begin
                if (cnt_q == LAST) begin
                    state_d = SDONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d       = CNT_W'(cnt_q + CNT_W'(1));
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(base_q + ADDR_W'(cnt_d));
                    mem_wdata_d = st_q[cnt_d];
                end
            end
            SDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            rdi_q       <= '0;
            st_q        <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wd_q        <= '0;
            wev_q       <= 1'b0;
            rd_out_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            rdi_q       <= rdi_d;
            st_q        <= st_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wd_q        <= wd_d;
            wev_q       <= wev_d;
            rd_out_q    <= rd_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.WD        = wd_q;
    assign bus.WEV       = wev_q;
    assign bus.RD        = rd_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu (WIDTH=16, ADDR_W=16).
// A behavioural memory answers reads one cycle after the address; words never
// written read back as addr ^ 16'h1100 (so mem[0x0100+i] = 0x1000+i).
// Expected addresses/data are queued when a request is issued and popped as
// the DUT produces each element. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_vector_lsu;
    typedef logic [15:0][15:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] exp_addr [$];
    logic [15:0] exp_data [$];

    vector_lsu_if #(.WIDTH(16), .ADDR_W(16)) bus ();
    vector_lsu #(.WIDTH(16), .ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] mem_data  [0:65535];
    logic        mem_valid [0:65535];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) mem_valid[i] <= 1'b0;
        end else if (bus.mem_we) begin
            mem_data[bus.mem_addr]  <= bus.mem_wdata;
            mem_valid[bus.mem_addr] <= 1'b1;
        end
        bus.mem_rdata <= mem_valid[bus.mem_addr] ? mem_data[bus.mem_addr]
                                                 : (bus.mem_addr ^ 16'h1100);
    end

    // Drive one request across a single rising edge; returns at the falling
    // edge of the first busy cycle.
    task automatic issue(input logic o, input logic [15:0] base,
                         input logic [4:0] rd, input vec_t data);
        bus.start     = 1'b1;
        bus.op        = o;
        bus.base_addr = base;
        bus.rd_idx    = rd;
        bus.st_data   = data;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 1'b0;
        bus.base_addr = '0;
        bus.rd_idx    = '0;
        bus.st_data   = '0;
        #2;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.WEV !== 1'b0 || bus.RD !== 5'd0 ||
            bus.mem_we !== 1'b0 || bus.mem_addr !== 16'd0 || bus.mem_wdata !== 16'd0 || bus.WD !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b wev=%b rd=%0d we=%b addr=%h wdata=%h wd=%h, all required 0",
                     bus.busy, bus.done, bus.WEV, bus.RD, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.WD);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    // Plain load at 0x0100 and a load that wraps past 0xFFFF.
    task automatic test_load();
        logic [15:0] bases [2];
        logic [4:0]  rds   [2];
        logic [15:0] a, d;
        vec_t        exp_vec;
        bases = '{16'h0100, 16'hFFF8};
        rds   = '{5'd5, 5'd9};
        for (int t = 0; t < 2; t++) begin
            exp_addr.delete();
            exp_data.delete();
            for (int i = 0; i < 16; i++) begin
                a = 16'(bases[t] + 16'(i));
                exp_addr.push_back(a);
                exp_data.push_back(a ^ 16'h1100);
                exp_vec[i] = a ^ 16'h1100;
            end
            issue(1'b0, bases[t], rds[t], '0);
            for (int c = 1; c <= 16; c++) begin
                a = exp_addr.pop_front();
                checks++;
                if (bus.mem_addr !== a || bus.mem_we !== 1'b0 || bus.busy !== 1'b1 || bus.WEV !== 1'b0) begin
                    errors++;
                    $display("FAIL load_addr t=%0d cyc=%0d addr=%h we=%b busy=%b wev=%b, required addr=%h we=0 busy=1 wev=0",
                             t, c, bus.mem_addr, bus.mem_we, bus.busy, bus.WEV, a);
                end
                @(negedge clk);
            end
            checks++;
            if (bus.WEV !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL load_llast t=%0d wev=%b done=%b busy=%b, required 0 0 1", t, bus.WEV, bus.done, bus.busy);
            end
            @(negedge clk);
            checks++;
            if (bus.WEV !== 1'b1 || bus.done !== 1'b1 || bus.RD !== rds[t] || bus.mem_addr !== 16'd0 || bus.mem_we !== 1'b0) begin
                errors++;
                $display("FAIL load_wb_cyc18 t=%0d wev=%b done=%b rd=%0d addr=%h we=%b, required 1 1 %0d 0000 0",
                         t, bus.WEV, bus.done, bus.RD, bus.mem_addr, bus.mem_we, rds[t]);
            end
            for (int i = 0; i < 16; i++) begin
                d = exp_data.pop_front();
                checks++;
                if (bus.WD[i] !== d) begin
                    errors++;
                    $display("FAIL load_lane t=%0d lane=%0d got=%h required=%h", t, i, bus.WD[i], d);
                end
            end
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.WEV !== 1'b0 || bus.WD !== exp_vec) begin
                errors++;
                $display("FAIL load_after t=%0d busy=%b done=%b wev=%b wd=%h, required 0 0 0 wd=%h",
                         t, bus.busy, bus.done, bus.WEV, bus.WD, exp_vec);
            end
        end
    endtask

    task automatic test_store();
        vec_t        v;
        logic [15:0] a, d;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'hA000 + 16'(i);
            exp_addr.push_back(16'h0200 + 16'(i));
            exp_data.push_back(v[i]);
        end
        issue(1'b1, 16'h0200, 5'd1, v);
        for (int c = 1; c <= 16; c++) begin
            a = exp_addr.pop_front();
            d = exp_data.pop_front();
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== a || bus.mem_wdata !== d || bus.WEV !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL store_write cyc=%0d we=%b addr=%h wdata=%h wev=%b done=%b, required 1 %h %h 0 0",
                         c, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.WEV, bus.done, a, d);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.mem_we !== 1'b0 || bus.busy !== 1'b1 || bus.mem_addr !== 16'd0 || bus.mem_wdata !== 16'd0) begin
            errors++;
            $display("FAIL store_sdone done=%b we=%b busy=%b addr=%h wdata=%h, required 1 0 1 0000 0000",
                     bus.done, bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL store_idle busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_ignored_start();
        logic [15:0] a;
        int          extra_done;
        exp_addr.delete();
        for (int i = 0; i < 16; i++) exp_addr.push_back(16'h0300 + 16'(i));
        issue(1'b0, 16'h0300, 5'd7, '0);
        for (int c = 1; c <= 17; c++) begin
            if (c <= 16) begin
                a = exp_addr.pop_front();
                checks++;
                if (bus.mem_addr !== a || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL ign_addr cyc=%0d addr=%h we=%b, required %h 0", c, bus.mem_addr, bus.mem_we, a);
                end
            end
            if (c == 5) begin
                bus.start     = 1'b1;
                bus.op        = 1'b1;
                bus.base_addr = 16'h0700;
                bus.st_data   = '1;
            end
            @(negedge clk);
            if (c == 5) bus.start = 1'b0;
        end
        checks++;
        if (bus.WEV !== 1'b1 || bus.RD !== 5'd7 || bus.WD[0] !== 16'h1200 || bus.WD[15] !== 16'h120F) begin
            errors++;
            $display("FAIL ign_wb wev=%b rd=%0d lane0=%h lane15=%h, required 1 7 1200 120f",
                     bus.WEV, bus.RD, bus.WD[0], bus.WD[15]);
        end
        extra_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1 || bus.mem_we === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin
            errors++;
            $display("FAIL ign_no_second_op active_cycles=%0d, required 0", extra_done);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] a;
        int          wev_seen;
        issue(1'b0, 16'h0400, 5'd3, '0);
        for (int c = 1; c < 8; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.WEV !== 1'b0 || bus.RD !== 5'd0 ||
            bus.mem_we !== 1'b0 || bus.mem_addr !== 16'd0 || bus.mem_wdata !== 16'd0 || bus.WD !== '0) begin
            errors++;
            $display("FAIL midrst_outputs busy=%b done=%b wev=%b rd=%0d we=%b addr=%h wdata=%h wd=%h, all required 0",
                     bus.busy, bus.done, bus.WEV, bus.RD, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.WD);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < 16; i++) begin
            exp_addr.push_back(16'h0500 + 16'(i));
            exp_data.push_back((16'h0500 + 16'(i)) ^ 16'h1100);
        end
        // Start in the same cycle reset is released: the first edge accepts it.
        issue(1'b0, 16'h0500, 5'd31, '0);
        wev_seen = 0;
        for (int c = 1; c <= 17; c++) begin
            if (bus.WEV === 1'b1) wev_seen++;
            if (c <= 16) begin
                a = exp_addr.pop_front();
                checks++;
                if (bus.mem_addr !== a || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_reload_addr cyc=%0d addr=%h busy=%b, required %h 1", c, bus.mem_addr, bus.busy, a);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (wev_seen !== 0 || bus.WEV !== 1'b1 || bus.RD !== 5'd31 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reload_wb early_wev=%0d wev=%b rd=%0d done=%b, required 0 1 31 1",
                     wev_seen, bus.WEV, bus.RD, bus.done);
        end
        for (int i = 0; i < 16; i++) begin
            a = exp_data.pop_front();
            checks++;
            if (bus.WD[i] !== a) begin
                errors++;
                $display("FAIL midrst_reload_lane lane=%0d got=%h required=%h", i, bus.WD[i], a);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        vec_t        v;
        logic [15:0] a;
        exp_data.delete();
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'hB000 + 16'(3 * i);
            exp_data.push_back(v[i]);
        end
        issue(1'b1, 16'h0600, 5'd0, v);
        for (int c = 1; c <= 16; c++) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_store_done done=%b, required 1", bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy=%b, required 0", bus.busy);
        end
        issue(1'b0, 16'h0600, 5'd12, '0);
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_addr !== 16'h0600) begin
            errors++;
            $display("FAIL b2b_load_accept busy=%b addr=%h, required 1 0600", bus.busy, bus.mem_addr);
        end
        for (int c = 2; c <= 18; c++) @(negedge clk);
        checks++;
        if (bus.WEV !== 1'b1 || bus.RD !== 5'd12 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load_wb wev=%b rd=%0d done=%b, required 1 12 1", bus.WEV, bus.RD, bus.done);
        end
        for (int i = 0; i < 16; i++) begin
            a = exp_data.pop_front();
            checks++;
            if (bus.WD[i] !== a) begin
                errors++;
                $display("FAIL b2b_lane lane=%0d got=%h required=%h", i, bus.WD[i], a);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_ignored_start();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_lsu.md
VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 Parameter WIDTH, default 16: bits per element and number of elements per vector.
REQ-002 Parameter ADDR_W, default 16: memory word-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 op  input  1  0 = vector load, 1 = vector store; sampled with start.
REQ-007 base_addr  input  ADDR_W  word address of element 0; sampled with start.
REQ-008 rd_idx  input  5  destination vector register for load; sampled with start.
REQ-009 st_data  input  [WIDTH-1:0][WIDTH-1:0]  store vector from register-file read port; sampled with start.
REQ-010 mem_addr  output  ADDR_W  memory word address.
REQ-011 mem_we  output  1  memory write strobe.
REQ-012 mem_wdata  output  WIDTH  memory write data.
REQ-013 mem_rdata  input  WIDTH  read data, valid the cycle after mem_addr is presented with mem_we=0.
REQ-014 WD  output  [WIDTH-1:0][WIDTH-1:0]  assembled load vector to register-file write port.
REQ-015 WEV  output  1  register-file write enable.
REQ-016 RD  output  5  register-file destination index.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, LLAST, WB, STORE, SDONE.
REQ-020 In IDLE, start=1 at a rising edge SHALL latch op, base_addr, rd_idx, st_data, clear element counter cnt to 0, and enter LOAD (op=0) or STORE (op=1).
REQ-021 start while busy=1 SHALL be ignored; no queuing.
REQ-022 In LOAD: mem_we=0, mem_addr=base+cnt; cnt increments each cycle; mem_rdata SHALL be captured into lane cnt-1 (bits [16*(cnt-1)+15 : 16*(cnt-1)] for WIDTH=16) when cnt>0; after cnt=WIDTH-1 is issued, enter LLAST.
REQ-023 In LLAST, mem_rdata SHALL be captured into lane WIDTH-1; next state WB.
REQ-024 In WB, WEV=1, RD=latched rd_idx, done=1 for exactly one cycle; next state IDLE.
REQ-025 Load latency SHALL be WIDTH+2 cycles from accepting edge to the WEV cycle (18 for WIDTH=16).
REQ-026 In STORE: mem_we=1, mem_addr=base+cnt, mem_wdata=latched st_data lane cnt; after cnt=WIDTH-1, enter SDONE.
REQ-027 In SDONE, done=1 for one cycle, mem_we=0; next state IDLE; store occupies WIDTH+1 cycles.
REQ-028 Address arithmetic SHALL be modulo 2^ADDR_W (base+cnt wraps past all-ones to 0).
REQ-029 WEV SHALL be 0 in every state except WB; mem_we SHALL be 0 in every state except STORE.
REQ-030 WD SHALL hold its last assembled value outside WB; only lanes written in the current load change.
REQ-031 mem_addr and mem_wdata SHALL be 0 in IDLE, WB, SDONE.
REQ-032 A new start SHALL be accepted in the cycle after WB or SDONE (back-to-back, one IDLE cycle).

Reset
REQ-033 rst=1 SHALL immediately force IDLE, cnt=0, and all outputs (WD, WEV, RD, busy, done, mem_addr, mem_we, mem_wdata) to 0.
REQ-034 Reset asserted mid-LOAD or mid-STORE SHALL abort the operation with no WEV and no further mem_we.
REQ-035 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-036 Load: base=0x0100, rd_idx=5, mem[0x0100+i]=0x1000+i -> addresses 0x0100..0x010F on consecutive cycles, WEV=1, RD=5, WD lane i=0x1000+i, done, exactly 18 cycles after start.
REQ-037 Store: base=0x0200, st_data lane i=0xA000+i -> 16 consecutive writes mem[0x0200+i]=0xA000+i, then done, busy low after 17 cycles.
REQ-038 Wrap: load base=0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007, data lanes in order.
REQ-039 Ignored start: pulse start with op=1 during cycle 5 of a load -> load completes unchanged, no mem_we, no second done.
REQ-040 Reset mid-load: rst at cycle 8 of load -> all outputs 0 immediately, no WEV; subsequent load rd_idx=31 completes normally.
REQ-041 Back-to-back: store then load started one cycle after store's done -> both complete, load WD reflects stored values.
